fv_bank_cntl: RTL and testbench
===============================

Name: fv_bank_cntl

Overview:
- Per-bank feature-vector (FV) read controller, directly upstream of the FV bus; one instance per FV SRAM bank.
- Arbitrates FV read requests from the Edge PEs round-robin and reads one FV_LEN-word vector from the bank's synchronous SRAM.
- Emits the vector as a tagged, sos/eos-framed beat stream (FV_bank_CNTL2Edge_PE); the bus routes each beat to the PE named by PE_tag.

Parameters:
- NUM_EDGE_PE, 4, number of requesting Edge PEs (≥2).
- FV_WIDTH, 16, bits per FV word.
- FV_LEN, 4, words per feature vector (power of 2, ≥1).
- ADDR_WIDTH, 8, SRAM word-address width; node index width NODE_W = ADDR_WIDTH - log2(FV_LEN).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_EDGE_PE  per-PE read request; held high until its grant.
- req_node  input  NUM_EDGE_PE x NODE_W  per-PE node index within this bank.
- req_grant  output  NUM_EDGE_PE  one-hot, one-cycle grant pulse (combinational from req_valid in IDLE).
- busy  output  1  high when not IDLE.
- sram_cen  output  1  SRAM chip enable, active-low.
- sram_addr  output  ADDR_WIDTH  SRAM word address.
- sram_q  input  FV_WIDTH  SRAM read data; valid the cycle after the address is presented.
- FV_bank_CNTL2Edge_PE_out  output  struct  {valid, PE_tag[log2 NUM_EDGE_PE], sos, eos, FV_data[FV_WIDTH]}.

Behaviour:
- Reset (async, reset=0): state IDLE, rr_ptr=0, beat counter 0, return pipeline cleared, all outputs 0, sram_cen=1.
- FSM states: IDLE, READ.
- IDLE:
  - If any req_valid is set, the round-robin winner is the first set bit scanning from rr_ptr upward with wrap.
  - Assert req_grant[winner] in the same cycle; latch tag=winner and base=req_node[winner]*FV_LEN.
  - Set rr_ptr=(winner+1) mod NUM_EDGE_PE; go to READ.
  - With no request, stay in IDLE; grant=0.
- READ: beat counter b=0..FV_LEN-1, one word per cycle, no stalls.
  - sram_cen=0, sram_addr=base+b.
  - Return pipeline register loads {valid=1, tag, sos=(b==0), eos=(b==FV_LEN-1)}.
  - At b==FV_LEN-1, go to IDLE and clear b.
- Output beat: during the cycle after the read, out.valid/PE_tag/sos/eos come from the return pipeline register and FV_data=sram_q.
  - When out.valid=0, every output field is 0.
- Latency: grant at cycle T; reads in T+1..T+FV_LEN; beat b on the output at T+2+b.
  - A new grant can occur at T+FV_LEN+1, so the output gap between back-to-back vectors is exactly 1 idle cycle.
- Requests arriving while in READ are not granted until IDLE; no request is ever dropped while held.
- FV_LEN=1: a single beat with sos=eos=1.
- Address arithmetic is unsigned ADDR_WIDTH bits; the maximum node index maps to the top FV_LEN words with no overflow.
- The bus applies no backpressure; the stream is never throttled.
- Reset mid-burst: the burst is abandoned, outputs go to 0 immediately, and no eos is emitted.
  - The granted PE has already dropped its request and must re-issue it after reset.
- A PE with req_valid=1 receives exactly one grant per request; req_node is sampled only in the grant cycle.

Decomposition:
- Shared package (sys_defs): FV_bank_CNTL2Edge_PE struct, Num_Edge_PE, Num_Banks_FV, FV width/length constants, derived tag and node widths.
- Sub-module rr_arbiter:
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any.
  - Purely combinational; rr_ptr stays in fv_bank_cntl.

Test Plan:
- After reset, PE2 requests node 3 (defaults) -> grant[2] at T; sram_addr 12,13,14,15 at T+1..T+4; out valid T+2..T+5, tag=2, sos only at T+2, eos only at T+5, data equals SRAM contents.
- PE0 and PE2 request simultaneously from reset -> PE0 granted first, PE2 granted at T+5; PE2's stream starts T+7 after one idle output cycle.
- PE1, PE2 and PE3 all held continuously with rr_ptr=2 -> grant order 2,3,1,2; no starvation; each grant exactly one cycle.
- Reset asserted at T+3 during a burst -> out.valid=0 and sram_cen=1 immediately; no eos emitted; after release, state is IDLE with rr_ptr=0.
- FV_LEN=1 build, PE3 requests node 255 -> sram_addr=255 at T+1; single beat at T+2 with sos=eos=1 and tag=3.
- Request raised while busy -> not granted until IDLE, then granted once; req_node changed before the grant -> the value present in the grant cycle is used.

Source files
------------

// File: rtl/fv_bank_cntl_pkg.sv
// Shared definitions for the feature-vector bank read controller:
// default sizes, derived widths and the beat bundle sent to the FV bus.
package fv_bank_cntl_pkg;

    localparam int DEF_NUM_EDGE_PE = 4;
    localparam int NUM_BANKS_FV    = 4;
    localparam int DEF_FV_WIDTH    = 16;
    localparam int DEF_FV_LEN      = 4;
    localparam int DEF_ADDR_WIDTH  = 8;

    localparam int TAG_W  = $clog2(DEF_NUM_EDGE_PE);
    localparam int LOG_FV = $clog2(DEF_FV_LEN);
    localparam int NODE_W = DEF_ADDR_WIDTH - LOG_FV;

    // One beat on the FV bus, routed to the PE named by PE_tag
    typedef struct packed {
        logic                    valid;
        logic [TAG_W-1:0]        PE_tag;
        logic                    sos;
        logic                    eos;
        logic [DEF_FV_WIDTH-1:0] FV_data;
    } FV_bank_CNTL2Edge_PE_t;

    // Beat framing registered alongside the SRAM read; data joins one cycle later
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             sos;
        logic             eos;
    } ret_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } fv_state_t;

    // Next round-robin pointer: one past the winner, wrapping at n
    function automatic int next_ptr(input int winner, input int n);
        return (winner == n - 1) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/fv_bank_cntl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping around; the pointer itself lives in the caller.
module fv_bank_cntl_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] winner,
    output logic             any
);

    // Scan from ptr upward with wrap and stop at the first requester
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                winner     = PTR_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fv_bank_cntl.sv
// Per-bank FV read controller: grants one Edge PE round-robin, reads its
// FV_LEN-word vector from the bank SRAM and streams it as framed beats.
module fv_bank_cntl
    import fv_bank_cntl_pkg::*;
#(
    parameter int NUM_EDGE_PE = DEF_NUM_EDGE_PE,
    parameter int FV_WIDTH    = DEF_FV_WIDTH,
    parameter int FV_LEN      = DEF_FV_LEN,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_EDGE_PE-1:0]     req_valid,
    input  logic [NUM_EDGE_PE-1:0]
                 [ADDR_WIDTH-$clog2(FV_LEN)-1:0] req_node,
    output logic [NUM_EDGE_PE-1:0]     req_grant,
    output logic                       busy,
    output logic                       sram_cen,
    output logic [ADDR_WIDTH-1:0]      sram_addr,
    input  logic [FV_WIDTH-1:0]        sram_q,
    output FV_bank_CNTL2Edge_PE_t      FV_bank_CNTL2Edge_PE_out
);

    localparam int LOG_LEN = $clog2(FV_LEN);
    localparam int LEN_W   = (LOG_LEN > 0) ? LOG_LEN : 1;
    localparam int PTR_W   = $clog2(NUM_EDGE_PE);
    localparam logic [LEN_W-1:0] LAST = LEN_W'(FV_LEN - 1);

    fv_state_t              state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       tag;
    logic [ADDR_WIDTH-1:0]  base;
    logic [LEN_W-1:0]       beat;
    ret_t                   ret;

    logic [NUM_EDGE_PE-1:0] arb_grant;
    logic [PTR_W-1:0]       arb_winner;
    logic                   arb_any;
    logic [ADDR_WIDTH-1:0]  node_base;
    logic [PTR_W-1:0]       ptr_next;

    fv_bank_cntl_rr_arbiter #(
        .N     (NUM_EDGE_PE),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (arb_grant),
        .winner (arb_winner),
        .any    (arb_any)
    );

    // Winner's node scaled to its first word address; pointer moves past it
    always_comb begin
        node_base = ADDR_WIDTH'(req_node[arb_winner]) << LOG_LEN;
        ptr_next  = PTR_W'(next_ptr(int'(arb_winner), NUM_EDGE_PE));
    end

    // Grant is only offered while idle, so a busy bank never drops a request
    always_comb begin
        req_grant = (state == IDLE) ? arb_grant : '0;
        busy      = (state == READ);
        sram_cen  = (state != READ);
        sram_addr = (state == READ) ? base + ADDR_WIDTH'(beat) : '0;
    end

    // Control FSM: latch winner in IDLE, walk the words of the vector in READ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            tag    <= '0;
            base   <= '0;
            beat   <= '0;
            ret    <= '0;
        end else begin
            ret <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        tag    <= arb_winner;
                        base   <= node_base;
                        rr_ptr <= ptr_next;
                        beat   <= '0;
                        state  <= READ;
                    end
                end
                READ: begin
                    ret.valid <= 1'b1;
                    ret.tag   <= TAG_W'(tag);
                    ret.sos   <= (beat == '0);
                    ret.eos   <= (beat == LAST);
                    if (beat == LAST) begin
                        beat  <= '0;
                        state <= IDLE;
                    end else begin
                        beat <= beat + LEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM data lands with the framing registered on the read cycle
    always_comb begin
        FV_bank_CNTL2Edge_PE_out         = '0;
        FV_bank_CNTL2Edge_PE_out.valid   = ret.valid;
        FV_bank_CNTL2Edge_PE_out.PE_tag  = ret.tag;
        FV_bank_CNTL2Edge_PE_out.sos     = ret.sos;
        FV_bank_CNTL2Edge_PE_out.eos     = ret.eos;
        if (ret.valid)
            FV_bank_CNTL2Edge_PE_out.FV_data = DEF_FV_WIDTH'(sram_q);
    end

endmodule

// File: tb/tb_fv_bank_cntl.sv
// Directed bench for fv_bank_cntl: cycle tables for single and
// back-to-back bursts, plus round-robin, reset, FV_LEN=1 and busy cases.
module tb_fv_bank_cntl;
    import fv_bank_cntl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [3:0]       req_valid = '0;
    logic [3:0][5:0]  req_node = '0;
    logic [3:0]       req_grant;
    logic             busy, sram_cen;
    logic [7:0]       sram_addr;
    logic [15:0]      sram_q = '0;
    FV_bank_CNTL2Edge_PE_t fv_out;

    logic [3:0]       req_valid1 = '0;
    logic [3:0][7:0]  req_node1 = '0;
    logic [3:0]       req_grant1;
    logic             busy1, sram_cen1;
    logic [7:0]       sram_addr1;
    logic [15:0]      sram_q1 = '0;
    FV_bank_CNTL2Edge_PE_t fv_out1;

    int checks = 0;
    int errors = 0;
    int eos_cnt = 0;
    logic mon_en = 1'b0;

    fv_bank_cntl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_node(req_node),
        .req_grant(req_grant), .busy(busy),
        .sram_cen(sram_cen), .sram_addr(sram_addr), .sram_q(sram_q),
        .FV_bank_CNTL2Edge_PE_out(fv_out)
    );

    fv_bank_cntl #(.FV_LEN(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_node(req_node1),
        .req_grant(req_grant1), .busy(busy1),
        .sram_cen(sram_cen1), .sram_addr(sram_addr1), .sram_q(sram_q1),
        .FV_bank_CNTL2Edge_PE_out(fv_out1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mv(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    always @(posedge clk) begin
        if (!sram_cen) sram_q <= mv(sram_addr);
        if (!sram_cen1) sram_q1 <= mv(sram_addr1);
    end

    always @(negedge clk)
        if (mon_en && fv_out.eos) eos_cnt <= eos_cnt + 1;

    typedef struct {
        logic [3:0]      req;
        logic [3:0][5:0] node;
        logic [3:0]      grant;
        logic            busy;
        logic            cen;
        logic [7:0]      addr;
        logic            v;
        logic [1:0]      tag;
        logic            sos;
        logic            eos;
        logic [15:0]     data;
    } vec_t;

    vec_t vec[19];

    function automatic vec_t mk(
        input logic [3:0] r, input logic [23:0] nd, input logic [3:0] g,
        input logic b, input logic c, input logic [7:0] a, input logic v,
        input logic [1:0] t, input logic s, input logic e,
        input logic [15:0] d);
        vec_t x;
        x.req = r; x.node = nd; x.grant = g; x.busy = b; x.cen = c;
        x.addr = a; x.v = v; x.tag = t; x.sos = s; x.eos = e; x.data = d;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_valid1 = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            req_valid = vec[i].req;
            req_node = vec[i].node;
            @(negedge clk);
            chk($sformatf("row%0d", i),
                {req_grant, busy, sram_cen, sram_addr, fv_out},
                {vec[i].grant, vec[i].busy, vec[i].cen, vec[i].addr,
                 vec[i].v, vec[i].tag, vec[i].sos, vec[i].eos,
                 vec[i].data});
            step();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [23:0] na, nb;
        logic [3:0]  exp_order [4];
        logic [3:0]  seen;
        bit found;

        na = {6'd0, 6'd3, 6'd0, 6'd0};
        nb = {6'd0, 6'd5, 6'd0, 6'd1};
        // single burst: PE2, node 3
        vec[0]  = mk(4'b0100, na, 4'b0100, 0, 1, 8'd0,  0, 0, 0, 0, 16'h0);
        vec[1]  = mk(4'b0000, na, 4'b0000, 1, 0, 8'd12, 0, 0, 0, 0, 16'h0);
        vec[2]  = mk(4'b0000, na, 4'b0000, 1, 0, 8'd13, 1, 2, 1, 0, mv(12));
        vec[3]  = mk(4'b0000, na, 4'b0000, 1, 0, 8'd14, 1, 2, 0, 0, mv(13));
        vec[4]  = mk(4'b0000, na, 4'b0000, 1, 0, 8'd15, 1, 2, 0, 0, mv(14));
        vec[5]  = mk(4'b0000, na, 4'b0000, 0, 1, 8'd0,  1, 2, 0, 1, mv(15));
        vec[6]  = mk(4'b0000, na, 4'b0000, 0, 1, 8'd0,  0, 0, 0, 0, 16'h0);
        // back-to-back: PE0 node 1 then PE2 node 5
        vec[7]  = mk(4'b0101, nb, 4'b0001, 0, 1, 8'd0,  0, 0, 0, 0, 16'h0);
        vec[8]  = mk(4'b0100, nb, 4'b0000, 1, 0, 8'd4,  0, 0, 0, 0, 16'h0);
        vec[9]  = mk(4'b0100, nb, 4'b0000, 1, 0, 8'd5,  1, 0, 1, 0, mv(4));
        vec[10] = mk(4'b0100, nb, 4'b0000, 1, 0, 8'd6,  1, 0, 0, 0, mv(5));
        vec[11] = mk(4'b0100, nb, 4'b0000, 1, 0, 8'd7,  1, 0, 0, 0, mv(6));
        vec[12] = mk(4'b0100, nb, 4'b0100, 0, 1, 8'd0,  1, 0, 0, 1, mv(7));
        vec[13] = mk(4'b0000, nb, 4'b0000, 1, 0, 8'd20, 0, 0, 0, 0, 16'h0);
        vec[14] = mk(4'b0000, nb, 4'b0000, 1, 0, 8'd21, 1, 2, 1, 0, mv(20));
        vec[15] = mk(4'b0000, nb, 4'b0000, 1, 0, 8'd22, 1, 2, 0, 0, mv(21));
        vec[16] = mk(4'b0000, nb, 4'b0000, 1, 0, 8'd23, 1, 2, 0, 0, mv(22));
        vec[17] = mk(4'b0000, nb, 4'b0000, 0, 1, 8'd0,  1, 2, 0, 1, mv(23));
        vec[18] = mk(4'b0000, nb, 4'b0000, 0, 1, 8'd0,  0, 0, 0, 0, 16'h0);

        // reset values
        @(negedge clk);
        chk("reset_main", {req_grant, busy, sram_cen, sram_addr, fv_out},
            {4'b0, 1'b0, 1'b1, 8'd0, 21'd0});
        chk("reset_len1", {req_grant1, busy1, sram_cen1, sram_addr1, fv_out1},
            {4'b0, 1'b0, 1'b1, 8'd0, 21'd0});

        do_reset();
        run_rows(0, 6);
        do_reset();
        run_rows(7, 18);

        // round robin with rr_ptr=2 and PE1..3 held
        do_reset();
        req_node = nb;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("rr_first", req_grant, 4'b0010);
        step();
        req_valid = 4'b1110;
        exp_order[0] = 4'b0100;
        exp_order[1] = 4'b1000;
        exp_order[2] = 4'b0010;
        exp_order[3] = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int c = 0; c < 20 && !found; c++) begin
                step();
                @(negedge clk);
                if (req_grant != '0) found = 1;
            end
            chk($sformatf("rr_order%0d", k), req_grant, exp_order[k]);
            step();
            @(negedge clk);
            chk($sformatf("rr_pulse%0d", k), req_grant, 4'b0000);
        end
        req_valid = '0;
        repeat (6) step();

        // reset in the middle of a burst
        do_reset();
        eos_cnt = 0;
        mon_en = 1'b1;
        req_node = na;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("mid_grant", req_grant, 4'b0100);
        step();
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("mid_outs", {busy, sram_cen, sram_addr, fv_out},
            {1'b0, 1'b1, 8'd0, 21'd0});
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) step();
        mon_en = 1'b0;
        chk("mid_no_eos", eos_cnt, 0);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("mid_ptr0", req_grant, 4'b0010);
        step();
        req_valid = '0;
        repeat (6) step();

        // FV_LEN=1 build: PE3, top node
        do_reset();
        req_node1 = {8'd255, 8'd0, 8'd0, 8'd0};
        req_valid1 = 4'b1000;
        @(negedge clk);
        chk("l1_grant", {req_grant1, busy1}, {4'b1000, 1'b0});
        step();
        req_valid1 = '0;
        @(negedge clk);
        chk("l1_read", {busy1, sram_cen1, sram_addr1, fv_out1.valid},
            {1'b1, 1'b0, 8'd255, 1'b0});
        step();
        @(negedge clk);
        chk("l1_beat", {busy1, fv_out1}, {1'b0, 1'b1, 2'd3, 1'b1, 1'b1, mv(255)});
        step();
        @(negedge clk);
        chk("l1_idle", fv_out1, 21'd0);

        // request raised while busy; node changes before the grant
        do_reset();
        req_node = {6'd0, 6'd0, 6'd0, 6'd1};
        req_valid = 4'b0001;
        @(negedge clk);
        chk("busy_first", req_grant, 4'b0001);
        seen = '0;
        step();
        req_valid = '0;
        @(negedge clk);
        seen |= req_grant;
        step();
        req_valid = 4'b1000;
        req_node[3] = 6'd7;
        @(negedge clk);
        seen |= req_grant;
        step();
        @(negedge clk);
        seen |= req_grant;
        step();
        req_node[3] = 6'd9;
        @(negedge clk);
        seen |= req_grant;
        chk("busy_hold", seen, 4'b0000);
        step();
        @(negedge clk);
        chk("busy_grant", req_grant, 4'b1000);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("busy_addr", {sram_cen, sram_addr}, {1'b0, 8'd36});
        seen = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            seen |= req_grant;
        end
        chk("busy_once", seen, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
